// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with request handshake, registered read and a
// hardware clear sweep. Optional parity protection: define RAM_PARITY_EN.
module sync_ram_clr #(
  parameter int unsigned         DATA_W   = 4,
  parameter int unsigned         ADDR_W   = 5,
  parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
`ifdef RAM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic              par_err_q, par_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  init_word;
  logic [MEM_W-1:0]  din_word;

`ifdef RAM_PARITY_EN
  assign init_word = {^INIT_VAL, INIT_VAL};
  assign din_word  = {^din, din};
`else
  assign init_word = INIT_VAL;
  assign din_word  = din;
`endif

  assign rd_word = mem[addr];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    par_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = din_word;

    if (state_q == ST_CLEAR) begin
      // Sweep owns the write port; req and clr are ignored until it finishes.
      mem_we     = 1'b1;
      mem_waddr  = clr_addr_q;
      mem_wdata  = init_word;
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) begin
        state_d = ST_IDLE;
      end
    end else begin
      if (clr) begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end else if (req && we) begin
        mem_we = 1'b1;
      end else if (req) begin
        q_d       = rd_word[DATA_W-1:0];
        q_valid_d = 1'b1;
`ifdef RAM_PARITY_EN
        par_err_d = rd_word[DATA_W] != (^rd_word[DATA_W-1:0]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      par_err_q  <= par_err_d;
    end
  end

  // Array has no reset; contents are initialised by the sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign q       = q_q;
  assign q_valid = q_valid_q;
`ifdef RAM_PARITY_EN
  assign par_err = par_err_q;
`else
  logic unused_par;
  assign unused_par = par_err_q ^ par_err_d;
`endif

endmodule

// File: tb/tb_sync_ram_clr.sv
// Bench for sync_ram_clr: directed table, hand sequences and random traffic
// against a sweep-free reference model; two instances with INIT_VAL 0 and 9.
module tb_sync_ram_clr;
  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr, req, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          ready0, qv0, ready9, qv9;
  logic [DW-1:0] q0, q9;
`ifdef RAM_PARITY_EN
  logic          pe0, pe9;
`endif

  sync_ram_clr #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .addr(addr), .din(din),
    .ready(ready0), .q(q0), .q_valid(qv0)
`ifdef RAM_PARITY_EN
    , .par_err(pe0)
`endif
  );

  sync_ram_clr #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(4'h9)) dut9 (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .we(we), .addr(addr), .din(din),
    .ready(ready9), .q(q9), .q_valid(qv9)
`ifdef RAM_PARITY_EN
    , .par_err(pe9)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a clear is modelled as an instant fill plus a busy timer.
  int            busy = 0;
  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] m9 [DEPTH];
  logic [DW-1:0] eq0 = '0, eq9 = '0;
  logic          ev = 1'b0;

  typedef struct {
    logic          clr;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_q;
    logic          exp_v;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = 4'h0;
      m9[i] = 4'h9;
    end
  endtask

  task automatic set_in(input logic r, input logic c, input logic rq, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    rst = r; clr = c; req = rq; we = w; addr = a; din = d;
  endtask

  task automatic tick();
    if (rst) begin
      busy = DEPTH; fill(); eq0 = '0; eq9 = '0; ev = 1'b0;
    end else if (busy > 0) begin
      busy--; ev = 1'b0;
    end else if (clr) begin
      busy = DEPTH; fill(); ev = 1'b0;
    end else if (req && we) begin
      m0[addr] = din; m9[addr] = din; ev = 1'b0;
    end else if (req) begin
      eq0 = m0[addr]; eq9 = m9[addr]; ev = 1'b1;
    end else begin
      ev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("ready0", 32'(ready0), 32'(busy == 0));
    chk("ready9", 32'(ready9), 32'(busy == 0));
    chk("q_valid0", 32'(qv0), 32'(ev));
    chk("q_valid9", 32'(qv9), 32'(ev));
    chk("q0", 32'(q0), 32'(eq0));
    chk("q9", 32'(q9), 32'(eq9));
`ifdef RAM_PARITY_EN
    chk("par_err0", 32'(pe0), 32'd0);
`endif
  endtask

  // Counts cycles with ready low, starting with the cycle after the triggering edge.
  task automatic count_busy(input string name);
    int n = 0;
    while (!ready0 && n < 100) begin
      n++;
      tick();
    end
    chk(name, 32'(n), 32'd32);
  endtask

  initial begin
    set_in(0, 0, 0, 0, '0, '0);
    @(posedge clk); #1;

    // Reset and sweep length
    set_in(1, 0, 0, 0, '0, '0);
    tick();
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_q", 32'(q0), 32'd0);
    chk("rst_qv", 32'(qv0), 32'd0);
    set_in(0, 0, 0, 0, '0, '0);
    count_busy("sweep_len_rst");

    set_in(0, 0, 1, 0, 5'd7, '0);
    tick();
    chk("rd7_q0", 32'(q0), 32'h0);
    chk("rd7_q9", 32'(q9), 32'h9);
    chk("rd7_qv", 32'(qv0), 32'd1);
    set_in(0, 0, 0, 0, '0, '0);
    tick();
    chk("rd7_strobe", 32'(qv0), 32'd0);
    chk("rd7_hold", 32'(q0), 32'h0);

    // Table: writes, back-to-back reads, read-after-write
    for (int i = 1; i <= 5; i++)
      tbl.push_back('{1'b0, 1'b1, 1'b1, 5'(i), 4'(i), 4'h0, 1'b0});
    for (int i = 1; i <= 5; i++)
      tbl.push_back('{1'b0, 1'b1, 1'b0, 5'(i), 4'h0, 4'(i), 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 5'd3, 4'hA, 4'h5, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 5'd3, 4'h0, 4'hA, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 5'd3, 4'h0, 4'hA, 1'b0});
    foreach (tbl[i]) begin
      set_in(0, tbl[i].clr, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].din);
      tick();
      chk($sformatf("tbl%0d_q", i), 32'(q0), 32'(tbl[i].exp_q));
      chk($sformatf("tbl%0d_qv", i), 32'(qv0), 32'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_rdy", i), 32'(ready0), 32'd1);
    end

    // clr beats a coincident write
    set_in(0, 1, 1, 1, 5'd2, 4'hF);
    tick();
    chk("clr_ready", 32'(ready0), 32'd0);
    set_in(0, 0, 0, 0, '0, '0);
    count_busy("sweep_len_clr");
    set_in(0, 0, 1, 0, 5'd2, '0);
    tick();
    chk("clr_rd2_q0", 32'(q0), 32'h0);
    chk("clr_rd2_q9", 32'(q9), 32'h9);
    chk("clr_rd2_qv", 32'(qv0), 32'd1);

    // rst mid-sweep restarts it; writes during the sweep are ignored
    set_in(1, 0, 0, 0, '0, '0);
    tick();
    set_in(0, 0, 1, 1, 5'd2, 4'h5);
    for (int i = 0; i < 10; i++) tick();
    set_in(1, 0, 1, 1, 5'd2, 4'h5);
    tick();
    set_in(0, 0, 1, 1, 5'd2, 4'h5);
    count_busy("sweep_len_restart");
    set_in(0, 0, 1, 0, 5'd2, '0);
    tick();
    chk("restart_rd2_q0", 32'(q0), 32'h0);
    chk("restart_rd2_q9", 32'(q9), 32'h9);

    // rst in the cycle after a read
    set_in(0, 0, 1, 1, 5'd1, 4'h7);
    tick();
    set_in(0, 0, 1, 0, 5'd1, '0);
    tick();
    chk("pre_rst_q", 32'(q0), 32'h7);
    set_in(1, 0, 0, 0, '0, '0);
    tick();
    chk("post_rst_q", 32'(q0), 32'h0);
    chk("post_rst_qv", 32'(qv0), 32'd0);
    set_in(0, 0, 0, 0, '0, '0);
    count_busy("sweep_len_rst2");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      tick();
      check_model();
    end

`ifdef RAM_PARITY_EN
    set_in(0, 0, 0, 0, '0, '0);
    while (!ready0 && busy < 100) tick();
    set_in(0, 0, 1, 1, 5'd4, 4'h6);
    tick();
    set_in(0, 0, 1, 1, 5'd5, 4'h3);
    tick();
    dut.mem[4] = dut.mem[4] ^ 5'b00001;
    set_in(0, 0, 1, 0, 5'd4, '0);
    tick();
    chk("par_bad_err", 32'(pe0), 32'd1);
    chk("par_bad_qv", 32'(qv0), 32'd1);
    set_in(0, 0, 1, 0, 5'd5, '0);
    tick();
    chk("par_good_err", 32'(pe0), 32'd0);
    chk("par_good_qv", 32'(qv0), 32'd1);
    set_in(0, 0, 0, 0, '0, '0);
    tick();
    chk("par_idle_err", 32'(pe0), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
